// File: rtl/mem_lane_ctrl.sv
// Load/store lane controller: aligns one request onto an NB-lane bus, splitting
// misaligned accesses into two beats, and returns right-justified, extended load data.

module mem_lane_byte #(
  parameter int NB   = 4,
  parameter int LANE = 0
) (
  input  logic [4:0] off,
  input  logic [4:0] nbytes,
  input  logic       fill,
  input  logic [7:0] src,
  output logic       be0,
  output logic       be1,
  output logic [7:0] dout
);
  localparam logic [4:0] LN    = 5'(LANE);
  localparam logic [4:0] LN_HI = 5'(LANE + NB);

  logic [4:0] last;

  assign last = off + nbytes;
  assign be0  = (LN >= off) && (LN < last);
  // Second-beat lane LANE holds byte address NB+LANE relative to the aligned base.
  assign be1  = (LN_HI < last);
  assign dout = (LN < nbytes) ? src : {8{fill}};
endmodule

module mem_lane_ctrl #(
  parameter int DW       = 32,
  parameter int SPLIT_EN = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_sign,
  input  logic [31:0]     req_addr,
  input  logic [DW-1:0]   req_wdata,
  output logic            bus_valid,
  output logic            bus_we,
  output logic [31:0]     bus_addr,
  output logic [DW/8-1:0] bus_be,
  output logic [DW-1:0]   bus_wdata,
  input  logic            bus_ack,
  input  logic [DW-1:0]   bus_rdata,
  output logic            rsp_valid,
  output logic            rsp_err,
  output logic [DW-1:0]   rsp_rdata
);
  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);
  localparam int SW = $clog2(DW);

  typedef struct packed {
    logic          we;
    logic [1:0]    size;
    logic          sign;
    logic [31:0]   addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t        state, nxt;
  req_t          r;
  logic          err;
  logic [DW-1:0] rd0, rd1;

  // Legality is judged on the incoming request so illegal ones never reach the bus.
  logic [4:0] in_off, in_nb;
  logic       in_mis, in_ill, accept;

  assign in_off = 5'(req_addr[OW-1:0]);
  assign in_nb  = 5'd1 << req_size;
  assign in_mis = (in_off + in_nb) > 5'(NB);
  assign in_ill = ((DW == 32) && (req_size == 2'd3)) || ((SPLIT_EN == 0) && in_mis);
  assign accept = (state == IDLE) && req_valid;

  logic [4:0] off, nbytes;
  logic       split, in_beat;

  assign off     = 5'(r.addr[OW-1:0]);
  assign nbytes  = 5'd1 << r.size;
  assign split   = (off + nbytes) > 5'(NB);
  assign in_beat = (state == BEAT0) || (state == BEAT1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      r     <= '0;
      err   <= 1'b0;
      rd0   <= '0;
      rd1   <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        r   <= '{we: req_we, size: req_size, sign: req_sign, addr: req_addr, wdata: req_wdata};
        err <= in_ill;
      end
      if (state == BEAT0 && bus_ack) rd0 <= bus_rdata;
      if (state == BEAT1 && bus_ack) rd1 <= bus_rdata;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (req_valid) nxt = in_ill ? RESP : BEAT0;
      BEAT0:   if (bus_ack) nxt = split ? BEAT1 : RESP;
      BEAT1:   if (bus_ack) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Load assembly: shifting the beat pair down by o bytes lines byte 0 up with lane 0.
  logic [2*DW-1:0]       pair, wdbl;
  logic [DW-1:0]         asm_w, rot_w;
  logic [NB-1:0][7:0]    asm_b, ext_b;
  logic [NB-1:0]         be0_v, be1_v;
  logic [SW-1:0]         sidx;
  logic                  fill;

  assign pair  = {rd1, rd0} >> {off, 3'b000};
  assign asm_w = pair[DW-1:0];
  assign asm_b = asm_w;
  assign wdbl  = {r.wdata, r.wdata} << {off, 3'b000};
  assign rot_w = wdbl[2*DW-1:DW];
  assign sidx  = SW'({nbytes, 3'b000} - 8'd1);
  assign fill  = r.sign & asm_w[sidx];

  for (genvar g = 0; g < NB; g++) begin : g_lane
    mem_lane_byte #(.NB(NB), .LANE(g)) u_lane (
      .off    (off),
      .nbytes (nbytes),
      .fill   (fill),
      .src    (asm_b[g]),
      .be0    (be0_v[g]),
      .be1    (be1_v[g]),
      .dout   (ext_b[g])
    );
  end

  always_comb begin
    req_ready = (state == IDLE);
    bus_valid = in_beat;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_be    = '0;
    bus_wdata = '0;
    rsp_valid = (state == RESP);
    rsp_err   = (state == RESP) && err;
    rsp_rdata = '0;
    if (in_beat) begin
      bus_we    = r.we;
      bus_addr  = {r.addr[31:OW], {OW{1'b0}}} + ((state == BEAT1) ? 32'(NB) : 32'd0);
      bus_be    = (state == BEAT0) ? be0_v : be1_v;
      bus_wdata = rot_w;
    end
    if (state == RESP && !err && !r.we) rsp_rdata = ext_b;
  end
endmodule

// File: tb/tb_mem_lane_ctrl.sv
// Bench for mem_lane_ctrl (DW=32): directed cases plus random traffic against a
// byte-address reference model; a second instance runs with splitting disabled.

module tb_mem_lane_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_sign;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        bus_valid, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid2, req_ready2, req_we2, req_sign2;
  logic [1:0]  req_size2;
  logic [31:0] req_addr2, req_wdata2;
  logic        bus_valid2, bus_we2, bus_ack2;
  logic [31:0] bus_addr2, bus_wdata2, bus_rdata2;
  logic [3:0]  bus_be2;
  logic        rsp_valid2, rsp_err2;
  logic [31:0] rsp_rdata2;

  always #5 clk = ~clk;

  mem_lane_ctrl #(.DW(32), .SPLIT_EN(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata)
  );

  mem_lane_ctrl #(.DW(32), .SPLIT_EN(0)) dut_ns (
    .clk(clk), .reset(reset),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2), .req_size(req_size2),
    .req_sign(req_sign2), .req_addr(req_addr2), .req_wdata(req_wdata2),
    .bus_valid(bus_valid2), .bus_we(bus_we2), .bus_addr(bus_addr2), .bus_be(bus_be2),
    .bus_wdata(bus_wdata2), .bus_ack(bus_ack2), .bus_rdata(bus_rdata2),
    .rsp_valid(rsp_valid2), .rsp_err(rsp_err2), .rsp_rdata(rsp_rdata2)
  );

  int total = 0;
  int passed = 0;

  logic [31:0] o_addr [2];
  logic [31:0] o_wd   [2];
  logic [3:0]  o_be   [2];
  logic [31:0] o_rsp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Reference: walk the S request bytes by absolute address to find beat and lane.
  task automatic run_txn(input logic we, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [31:0] wdata, input int dly,
                         input logic [31:0] rd0, input logic [31:0] rd1);
    int          s, o, nbeats, bt, ln;
    logic        legal;
    logic [31:0] a, wd, rsp;
    logic [31:0] ba [2];
    logic [31:0] rdv [2];
    logic [3:0]  be [2];
    logic [7:0]  res [4];
    rdv[0] = rd0; rdv[1] = rd1;
    s = 1 << size;
    o = int'(addr % 32'd4);
    legal = (size != 2'd3);
    be[0] = '0; be[1] = '0; nbeats = 1;
    for (int k = 0; k < 4; k++) res[k] = 8'h00;
    if (legal) begin
      for (int k = 0; k < s; k++) begin
        a  = addr + 32'(k);
        bt = int'(a / 32'd4) - int'(addr / 32'd4);
        ln = int'(a % 32'd4);
        be[bt][ln] = 1'b1;
        res[k] = rdv[bt][8*ln +: 8];
        if (bt == 1) nbeats = 2;
      end
    end
    ba[0] = addr - (addr % 32'd4);
    ba[1] = ba[0] + 32'd4;
    for (int l = 0; l < 4; l++) wd[8*l +: 8] = wdata[8*((l - o + 4) % 4) +: 8];
    rsp = '0;
    if (legal && !we)
      for (int k = 0; k < 4; k++)
        rsp[8*k +: 8] = (k < s) ? res[k] : (sign ? {8{res[s-1][7]}} : 8'h00);

    chk("idle_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_sign = sign;
    req_addr = addr; req_wdata = wdata;
    bus_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_sign = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    if (!legal) begin
      bus_ack = 1'b0;
      chk("ill_busv", {31'd0, bus_valid}, 32'd0);
      chk("ill_rspv", {31'd0, rsp_valid}, 32'd1);
      chk("ill_err", {31'd0, rsp_err}, 32'd1);
      chk("ill_rdata", rsp_rdata, 32'd0);
      o_rsp = rsp_rdata;
    end else begin
      for (int b = 0; b < nbeats; b++) begin
        for (int w = 0; w <= dly; w++) begin
          chk("busv", {31'd0, bus_valid}, 32'd1);
          chk("bus_addr", bus_addr, ba[b]);
          chk("bus_be", {28'd0, bus_be}, {28'd0, be[b]});
          chk("bus_wdata", bus_wdata, wd);
          chk("bus_we", {31'd0, bus_we}, {31'd0, we});
          chk("busy_ready", {31'd0, req_ready}, 32'd0);
          chk("busy_rspv", {31'd0, rsp_valid}, 32'd0);
          o_addr[b] = bus_addr; o_be[b] = bus_be; o_wd[b] = bus_wdata;
          bus_ack   = (w == dly);
          bus_rdata = (w == dly) ? rdv[b] : $urandom;
          @(negedge clk);
        end
      end
      bus_ack = 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
      chk("rspv", {31'd0, rsp_valid}, 32'd1);
      chk("rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("rsp_rdata", rsp_rdata, rsp);
      chk("rsp_busv", {31'd0, bus_valid}, 32'd0);
      o_rsp = rsp_rdata;
    end
    @(negedge clk);
    bus_ack = 1'b0;
    chk("post_rspv", {31'd0, rsp_valid}, 32'd0);
    chk("post_ready", {31'd0, req_ready}, 32'd1);
    chk("post_busv", {31'd0, bus_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_sign = 1'b0;
    req_addr = '0; req_wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
    req_valid2 = 1'b0; req_we2 = 1'b0; req_size2 = 2'd0; req_sign2 = 1'b0;
    req_addr2 = '0; req_wdata2 = '0; bus_ack2 = 1'b0; bus_rdata2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busv", {31'd0, bus_valid}, 32'd0);
    chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_rspv", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Byte store into the top lane
    run_txn(1'b1, 2'd0, 1'b0, 32'h1003, 32'h0000_00AB, 0, $urandom, $urandom);
    chk("d22_addr", o_addr[0], 32'h1000);
    chk("d22_be", {28'd0, o_be[0]}, 32'h8);
    chk("d22_wdata", o_wd[0], 32'hAB00_0000);
    chk("d22_rdata", o_rsp, 32'h0);

    // Half loads, signed then unsigned
    run_txn(1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 0, 32'h8001_1234, $urandom);
    chk("d23_be", {28'd0, o_be[0]}, 32'hC);
    chk("d23_signed", o_rsp, 32'hFFFF_8001);
    run_txn(1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 0, 32'h8001_1234, $urandom);
    chk("d23_unsigned", o_rsp, 32'h0000_8001);

    // Split word load
    run_txn(1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 0, 32'h4433_2211, 32'h0000_0055);
    chk("d24_addr0", o_addr[0], 32'h3000);
    chk("d24_be0", {28'd0, o_be[0]}, 32'hE);
    chk("d24_addr1", o_addr[1], 32'h3004);
    chk("d24_be1", {28'd0, o_be[1]}, 32'h1);
    chk("d24_rdata", o_rsp, 32'h5544_3322);

    // Illegal dword on a 32-bit bus, then ack withheld 5 cycles on a split store
    run_txn(1'b0, 2'd3, 1'b1, 32'h5000, 32'h0, 0, $urandom, $urandom);
    run_txn(1'b1, 2'd2, 1'b0, 32'h4002, 32'h1234_5678, 5, $urandom, $urandom);

    // No-split instance: misaligned word is rejected, aligned word works
    req_valid2 = 1'b1; req_size2 = 2'd2; req_addr2 = 32'h3001;
    @(negedge clk);
    req_valid2 = 1'b0;
    chk("ns_busv", {31'd0, bus_valid2}, 32'd0);
    chk("ns_rspv", {31'd0, rsp_valid2}, 32'd1);
    chk("ns_err", {31'd0, rsp_err2}, 32'd1);
    chk("ns_rdata", rsp_rdata2, 32'd0);
    @(negedge clk);
    chk("ns_ready", {31'd0, req_ready2}, 32'd1);
    req_valid2 = 1'b1; req_addr2 = 32'h3000;
    @(negedge clk);
    req_valid2 = 1'b0;
    chk("ns_ok_busv", {31'd0, bus_valid2}, 32'd1);
    chk("ns_ok_be", {28'd0, bus_be2}, 32'hF);
    bus_ack2 = 1'b1; bus_rdata2 = 32'hCAFE_F00D;
    @(negedge clk);
    bus_ack2 = 1'b0;
    chk("ns_ok_err", {31'd0, rsp_err2}, 32'd0);
    chk("ns_ok_rdata", rsp_rdata2, 32'hCAFE_F00D);

    // Reset during the second beat of a split store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h1002;
    req_wdata = 32'hDDCC_BBAA;
    @(negedge clk);
    req_valid = 1'b0;
    chk("r27_be0", {28'd0, bus_be}, 32'hC);
    chk("r27_wdata", bus_wdata, 32'hBBAA_DDCC);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("r27_addr1", bus_addr, 32'h1004);
    chk("r27_be1", {28'd0, bus_be}, 32'h3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("r27_busv", {31'd0, bus_valid}, 32'd0);
    chk("r27_ready", {31'd0, req_ready}, 32'd1);
    chk("r27_rspv", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("r27_norsp", {31'd0, rsp_valid}, 32'd0);
    run_txn(1'b0, 2'd2, 1'b1, 32'h6003, 32'h0, 1, 32'h8877_6655, 32'h0099_AABB);

    // Random traffic
    for (int i = 0; i < 60; i++)
      run_txn(1'($urandom), 2'($urandom), 1'($urandom), $urandom_range(0, 32'hFFFF_0000),
              $urandom, $urandom_range(0, 3), $urandom, $urandom);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
